dyn_compressor: RTL and testbench

- Parametrised, envelope-driven dynamic range compressor and limiter for signed audio samples. It is the next generation of the fixed 8-bit compressor.
- Adds configurable width, threshold, ratio and attack/release, a runtime mode select, a valid handshake and a gain-reduction meter output.
- Sits in the DSP chain between sample source and DAC/board top, with one sample per i_valid strobe.

---
 rtl/dyn_comp_pkg.sv | 33 +++
 rtl/dyn_comp_envelope.sv | 53 +++++
 rtl/dyn_compressor.sv | 167 ++++++++++++++++
 tb/tb_dyn_compressor.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_comp_pkg.sv
// dyn_comp_pkg: shared definitions for the dynamic range compressor.
//   - mode_t        : runtime processing mode carried alongside each sample
//   - LATENCY       : register stages from i_valid to o_valid
//   - ABS_MAX_W     : widest sample the saturated-abs helper supports
//   - sat_abs()     : magnitude of a two's complement value of width w, with
//                     the most negative code clamped to the largest positive
package dyn_comp_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_COMP     = 2'b01,
    MODE_LIMIT    = 2'b10,
    MODE_COMP_LIM = 2'b11
  } mode_t;

  localparam int LATENCY   = 3;
  localparam int ABS_MAX_W = 32;

  // x must be sign-extended from w bits to ABS_MAX_W bits by the caller.
  // The negation is done on the unsigned view so -2^(ABS_MAX_W-1) still
  // yields its true magnitude before the clamp.
  function automatic logic [ABS_MAX_W-1:0] sat_abs(
    input logic [ABS_MAX_W-1:0] x,
    input int unsigned          w
  );
    logic [ABS_MAX_W-1:0] mag;
    logic [ABS_MAX_W-1:0] lim;
    lim = (ABS_MAX_W'(1) << (w - 1)) - ABS_MAX_W'(1);
    mag = x[ABS_MAX_W-1] ? (~x + ABS_MAX_W'(1)) : x;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/dyn_comp_envelope.sv
// dyn_comp_envelope: asymmetric peak-following envelope detector.
//   clk      : system clock
//   reset    : synchronous active-high reset, clears the envelope
//   valid    : a new magnitude is present on abs; env advances this edge
//   abs      : unsigned sample magnitude (DATA_W-1 bits)
//   env_next : envelope value that results from applying abs to env
//              (computed every cycle; only committed when valid is high)
//   env      : current envelope register
// The envelope moves toward abs by a shifted fraction of the gap, with a
// minimum step of 1 so a constant input always lands exactly on abs. The
// step never exceeds the gap, so the envelope can neither overflow nor
// overshoot.
module dyn_comp_envelope #(
  parameter int DATA_W     = 16,
  parameter int ATTACK_SH  = 2,
  parameter int RELEASE_SH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-2:0] abs,
  output logic [DATA_W-2:0] env_next,
  output logic [DATA_W-2:0] env
);

  localparam int EW = DATA_W - 1;

  logic [EW-1:0] diff_up;
  logic [EW-1:0] diff_dn;
  logic [EW-1:0] step_up;
  logic [EW-1:0] step_dn;

  always_comb begin
    diff_up = abs - env;
    diff_dn = env - abs;
    step_up = diff_up >> ATTACK_SH;
    if (step_up == '0) step_up = EW'(1);
    step_dn = diff_dn >> RELEASE_SH;
    if (step_dn == '0) step_dn = EW'(1);
    if (abs > env)      env_next = env + step_up;
    else if (abs < env) env_next = env - step_dn;
    else                env_next = env;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      env <= '0;
    end else if (valid) begin
      env <= env_next;
    end
  end

endmodule

// File: rtl/dyn_compressor.sv
// dyn_compressor: envelope-driven compressor / limiter for signed samples.
//   i_clk   : system clock
//   i_reset : synchronous active-high reset; drops samples in flight
//   i_valid : sample strobe; i_data and i_mode are captured when high
//   i_data  : signed input sample (DATA_W bits)
//   i_mode  : 00 bypass, 01 compress, 10 limit, 11 compress then limit
//   o_valid : one-cycle strobe marking a new o_data / o_gr
//   o_data  : signed output sample
//   o_gr    : gain reduction applied to this sample, in magnitude units
//
// Handshake: a sample is accepted on every rising edge where i_valid is
// high; there is no ready, so the source must never expect backpressure.
// o_valid is high for exactly one cycle, LATENCY-1 edges after the accepting
// edge, and is low on any cycle with no sample. o_data / o_gr hold their
// last values while o_valid is low.
//
// Pipeline:
//   stage 1 : raw sample, sign, mode, saturated magnitude
//   stage 2 : same fields plus the envelope value this sample produced
//             (the envelope register itself is updated on the same edge)
//   stage 3 : gain computation and sign restore, registered into outputs
module dyn_compressor
  import dyn_comp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int THRESH     = 8192,
  parameter int RATIO_SH   = 2,
  parameter int ATTACK_SH  = 2,
  parameter int RELEASE_SH = 6
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic        [1:0]        i_mode,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_data,
  output logic        [DATA_W-2:0] o_gr
);

  localparam int            EW       = DATA_W - 1;
  localparam logic [EW-1:0] THRESH_U = EW'(THRESH);

  // ---------------- stage 1 ----------------
  logic              s1_valid;
  logic [DATA_W-1:0] s1_raw;
  logic              s1_sign;
  mode_t             s1_mode;
  logic [EW-1:0]     s1_abs;
  logic [EW-1:0]     in_abs;

  assign in_abs = EW'(sat_abs(ABS_MAX_W'(i_data), DATA_W));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_sign  <= 1'b0;
      s1_mode  <= MODE_BYPASS;
      s1_abs   <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_raw  <= i_data;
        s1_sign <= i_data[DATA_W-1];
        s1_mode <= mode_t'(i_mode);
        s1_abs  <= in_abs;
      end
    end
  end

  // ---------------- envelope ----------------
  logic [EW-1:0] env_next;
  logic [EW-1:0] env;

  dyn_comp_envelope #(
    .DATA_W     (DATA_W),
    .ATTACK_SH  (ATTACK_SH),
    .RELEASE_SH (RELEASE_SH)
  ) u_env (
    .clk      (i_clk),
    .reset    (i_reset),
    .valid    (s1_valid),
    .abs      (s1_abs),
    .env_next (env_next),
    .env      (env)
  );

  // ---------------- stage 2 ----------------
  logic              s2_valid;
  logic [DATA_W-1:0] s2_raw;
  logic              s2_sign;
  mode_t             s2_mode;
  logic [EW-1:0]     s2_abs;
  logic [EW-1:0]     s2_env;

  // Stage 2 data is reloaded every cycle; stage 3 only consumes it when
  // s2_valid is set. On a bubble the held envelope is carried instead of
  // the candidate update, which was not committed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid <= 1'b0;
      s2_raw   <= '0;
      s2_sign  <= 1'b0;
      s2_mode  <= MODE_BYPASS;
      s2_abs   <= '0;
      s2_env   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_raw   <= s1_raw;
      s2_sign  <= s1_sign;
      s2_mode  <= s1_mode;
      s2_abs   <= s1_abs;
      s2_env   <= s1_valid ? env_next : env;
    end
  end

  // ---------------- stage 3 ----------------
  logic [EW-1:0]     excess;
  logic [EW-1:0]     red;
  logic [EW-1:0]     cmag;
  logic [EW-1:0]     mag;
  logic [EW-1:0]     out_gr;
  logic [DATA_W-1:0] mag_ext;
  logic [DATA_W-1:0] out_data;

  always_comb begin
    // Reduction is the part of the overshoot the ratio removes:
    // excess - excess/2^RATIO_SH.
    excess = s2_env - THRESH_U;
    red    = (s2_env > THRESH_U) ? (excess - (excess >> RATIO_SH)) : '0;
    cmag   = (s2_abs > red) ? (s2_abs - red) : '0;

    mag = s2_abs;
    case (s2_mode)
      MODE_BYPASS:   mag = s2_abs;
      MODE_COMP:     mag = cmag;
      MODE_LIMIT:    mag = (s2_abs > THRESH_U) ? THRESH_U : s2_abs;
      MODE_COMP_LIM: mag = (cmag > THRESH_U) ? THRESH_U : cmag;
    endcase

    // mag fits in DATA_W-1 bits, so negating it cannot overflow.
    mag_ext = {1'b0, mag};
    if (s2_mode == MODE_BYPASS) begin
      out_data = s2_raw;
      out_gr   = '0;
    end else begin
      out_data = s2_sign ? (~mag_ext + DATA_W'(1)) : mag_ext;
      out_gr   = s2_abs - mag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_gr    <= '0;
    end else begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_data <= out_data;
        o_gr   <= out_gr;
      end
    end
  end

endmodule

// File: tb/tb_dyn_compressor.sv
// tb_dyn_compressor: directed self-checking bench for dyn_compressor with
// default parameters (DATA_W=16, THRESH=8192, RATIO 4:1, ATTACK_SH=2,
// RELEASE_SH=6). Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point or on the falling edge.
module tb_dyn_compressor;
  import dyn_comp_pkg::*;

  localparam int DATA_W = 16;

  logic                     i_clk = 1'b0;
  logic                     i_reset;
  logic                     i_valid;
  logic signed [DATA_W-1:0] i_data;
  logic        [1:0]        i_mode;
  logic                     o_valid;
  logic signed [DATA_W-1:0] o_data;
  logic        [DATA_W-2:0] o_gr;

  int n_checks = 0;
  int n_fail   = 0;

  // Captured output samples (one entry per o_valid cycle).
  logic [DATA_W-1:0] got_d[$];
  logic [DATA_W-2:0] got_g[$];

  dyn_compressor dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_gr    (o_gr)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- output capture ----------------
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      got_d.push_back(o_data);
      got_g.push_back(o_gr);
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [1:0] m);
    i_valid = 1'b1;
    i_data  = d;
    i_mode  = m;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_n(input logic [DATA_W-1:0] d, input logic [1:0] m, input int n);
    for (int k = 0; k < n; k++) send(d, m);
  endtask

  task automatic drain();
    idle(LATENCY + 1);
  endtask

  task automatic clear_q();
    got_d.delete();
    got_g.delete();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    idle(2);
    i_reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_mode  = 2'b00;
    idle(3);
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== 16'sd0 || o_gr !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%0d gr=%0d, want v=0 d=0 gr=0", o_valid, o_data, o_gr);
    end
    i_reset = 1'b0;
    idle(1);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_valid: got %b want 0", o_valid);
    end
  endtask

  task automatic test_bypass();
    logic       exp_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_d[4] = '{16'd100, 16'd100, 16'd200, 16'd200};
    send(16'h8000, MODE_BYPASS);   // edge N
    send(16'd1234, MODE_BYPASS);   // edge N+1
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_latency_early: o_valid=%b after N+1, want 0", o_valid);
    end
    @(posedge i_clk); #1;          // after N+2
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== -16'sd32768 || o_gr !== 15'd0) begin
      n_fail++;
      $display("FAIL bypass_most_neg: got v=%b d=%0d gr=%0d, want v=1 d=-32768 gr=0", o_valid, o_data, o_gr);
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 16'sd1234 || o_gr !== 15'd0) begin
      n_fail++;
      $display("FAIL bypass_second: got v=%b d=%0d gr=%0d, want v=1 d=1234 gr=0", o_valid, o_data, o_gr);
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== 16'sd1234) begin
      n_fail++;
      $display("FAIL bypass_hold: got v=%b d=%0d, want v=0 d=1234", o_valid, o_data);
    end
    // Gap in the input must appear as a gap at the output.
    send(16'd100, MODE_BYPASS);
    idle(1);
    send(16'd200, MODE_BYPASS);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_valid !== exp_v[k] || o_data !== exp_d[k]) begin
        n_fail++;
        $display("FAIL bypass_gap[%0d]: got v=%b d=%0d, want v=%b d=%0d", k, o_valid, o_data, exp_v[k], exp_d[k]);
      end
      idle(1);
    end
  endtask

  task automatic test_limit();
    logic [15:0] exp_d[3] = '{16'd8192, -16'sd8192, 16'd5000};
    logic [14:0] exp_g[3] = '{15'd11808, 15'd11808, 15'd0};
    logic [15:0] d;
    logic [14:0] g;
    clear_q();
    send(16'd20000, MODE_LIMIT);
    send(-16'sd20000, MODE_LIMIT);
    send(16'd5000, MODE_LIMIT);
    drain();
    n_checks++;
    if (got_d.size() != 3) begin
      n_fail++;
      $display("FAIL limit_count: got %0d samples, want 3", got_d.size());
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_d.size() == 0) begin
        n_fail++;
        $display("FAIL limit[%0d]: no sample, want d=%0d", k, $signed(exp_d[k]));
      end else begin
        d = got_d.pop_front();
        g = got_g.pop_front();
        if (d !== exp_d[k] || g !== exp_g[k]) begin
          n_fail++;
          $display("FAIL limit[%0d]: got d=%0d gr=%0d, want d=%0d gr=%0d", k, $signed(d), g, $signed(exp_d[k]), exp_g[k]);
        end
      end
    end
  endtask

  // Envelope 0 -> 4000 -> 7000 -> 9250; only the third crosses the threshold.
  task automatic test_compress_attack();
    logic [15:0] exp_d[3] = '{16'd16000, 16'd16000, 16'd15206};
    logic [14:0] exp_g[3] = '{15'd0, 15'd0, 15'd794};
    logic [15:0] d;
    logic [14:0] g;
    do_reset();
    clear_q();
    send_n(16'd16000, MODE_COMP, 3);
    drain();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_d.size() == 0) begin
        n_fail++;
        $display("FAIL attack[%0d]: no sample, want d=%0d", k, exp_d[k]);
      end else begin
        d = got_d.pop_front();
        g = got_g.pop_front();
        if (d !== exp_d[k] || g !== exp_g[k]) begin
          n_fail++;
          $display("FAIL attack[%0d]: got d=%0d gr=%0d, want d=%0d gr=%0d", k, $signed(d), g, exp_d[k], exp_g[k]);
        end
      end
    end
  endtask

  task automatic test_steady();
    logic [15:0] d;
    logic [14:0] g;
    clear_q();
    send_n(16'd24576, MODE_COMP, 220);
    drain();
    n_checks++;
    if (got_d.size() != 220) begin
      n_fail++;
      $display("FAIL steady_pos: got %0d samples, want 220", got_d.size());
    end else begin
      d = got_d[$];
      g = got_g[$];
      if (d !== 16'd12288 || g !== 15'd12288) begin
        n_fail++;
        $display("FAIL steady_pos: got d=%0d gr=%0d, want d=12288 gr=12288", $signed(d), g);
      end
    end
    clear_q();
    send_n(-16'sd24576, MODE_COMP, 20);
    drain();
    n_checks++;
    if (got_d.size() != 20) begin
      n_fail++;
      $display("FAIL steady_neg: got %0d samples, want 20", got_d.size());
    end else begin
      d = got_d[$];
      g = got_g[$];
      if (d !== -16'sd12288 || g !== 15'd12288) begin
        n_fail++;
        $display("FAIL steady_neg: got d=%0d gr=%0d, want d=-12288 gr=12288", $signed(d), g);
      end
    end
  endtask

  // First release sample: env 24576 -> 24255, reduction 12048 > 4000 so the
  // output is fully squashed. After enough samples env settles at 4000.
  task automatic test_release();
    logic [15:0] d;
    logic [14:0] g;
    clear_q();
    send(16'd4000, MODE_COMP);
    drain();
    n_checks++;
    if (got_d.size() != 1) begin
      n_fail++;
      $display("FAIL release_first: got %0d samples, want 1", got_d.size());
    end else begin
      d = got_d[0];
      g = got_g[0];
      if (d !== 16'd0 || g !== 15'd4000) begin
        n_fail++;
        $display("FAIL release_first: got d=%0d gr=%0d, want d=0 gr=4000", $signed(d), g);
      end
    end
    clear_q();
    send_n(16'd4000, MODE_COMP, 800);
    drain();
    n_checks++;
    if (got_d.size() != 800) begin
      n_fail++;
      $display("FAIL release_settled: got %0d samples, want 800", got_d.size());
    end else begin
      d = got_d[$];
      g = got_g[$];
      if (d !== 16'd4000 || g !== 15'd0) begin
        n_fail++;
        $display("FAIL release_settled: got d=%0d gr=%0d, want d=4000 gr=0", $signed(d), g);
      end
    end
  endtask

  // env 30000: reduction 16356, cmag 13644, limited to 8192, gr 21808.
  task automatic test_comp_lim();
    logic [15:0] d;
    logic [14:0] g;
    clear_q();
    send_n(16'd30000, MODE_COMP_LIM, 150);
    send(-16'sd30000, MODE_COMP_LIM);
    drain();
    n_checks++;
    if (got_d.size() != 151) begin
      n_fail++;
      $display("FAIL comp_lim_count: got %0d samples, want 151", got_d.size());
    end else begin
      d = got_d[149];
      g = got_g[149];
      if (d !== 16'd8192 || g !== 15'd21808) begin
        n_fail++;
        $display("FAIL comp_lim_pos: got d=%0d gr=%0d, want d=8192 gr=21808", $signed(d), g);
      end
      n_checks++;
      d = got_d[150];
      g = got_g[150];
      if (d !== -16'sd8192 || g !== 15'd21808) begin
        n_fail++;
        $display("FAIL comp_lim_neg: got d=%0d gr=%0d, want d=-8192 gr=21808", $signed(d), g);
      end
    end
  endtask

  // Starting from env 30000, three back-to-back 20000 samples in different
  // modes: env 29844, 29691, 29540. The third (compress) sees reduction
  // 21348 - 5337 = 16011, giving 3989.
  task automatic test_mode_change();
    logic [15:0] exp_d[3] = '{16'd20000, 16'd8192, 16'd3989};
    logic [14:0] exp_g[3] = '{15'd0, 15'd11808, 15'd16011};
    logic [15:0] d;
    logic [14:0] g;
    clear_q();
    send(16'd20000, MODE_BYPASS);
    send(16'd20000, MODE_LIMIT);
    send(16'd20000, MODE_COMP);
    drain();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_d.size() == 0) begin
        n_fail++;
        $display("FAIL mode_change[%0d]: no sample, want d=%0d", k, exp_d[k]);
      end else begin
        d = got_d.pop_front();
        g = got_g.pop_front();
        if (d !== exp_d[k] || g !== exp_g[k]) begin
          n_fail++;
          $display("FAIL mode_change[%0d]: got d=%0d gr=%0d, want d=%0d gr=%0d", k, $signed(d), g, exp_d[k], exp_g[k]);
        end
      end
    end
  endtask

  // Envelope is high (~29540) before this; reset must clear it and drop the
  // two samples in flight.
  task automatic test_reset_in_flight();
    logic [15:0] d;
    logic [14:0] g;
    clear_q();
    send(16'd16000, MODE_COMP);
    send(16'd17000, MODE_COMP);
    i_reset = 1'b1;
    idle(1);
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== 16'sd0 || o_gr !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_flight_out: got v=%b d=%0d gr=%0d, want v=0 d=0 gr=0", o_valid, o_data, o_gr);
    end
    i_reset = 1'b0;
    idle(3);
    n_checks++;
    if (got_d.size() != 0) begin
      n_fail++;
      $display("FAIL reset_flight_drop: got %0d samples, want 0", got_d.size());
    end
    clear_q();
    send(16'd16000, MODE_COMP);
    drain();
    n_checks++;
    if (got_d.size() != 1) begin
      n_fail++;
      $display("FAIL reset_restart: got %0d samples, want 1", got_d.size());
    end else begin
      d = got_d[0];
      g = got_g[0];
      if (d !== 16'd16000 || g !== 15'd0) begin
        n_fail++;
        $display("FAIL reset_restart: got d=%0d gr=%0d, want d=16000 gr=0", $signed(d), g);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bypass();
    test_limit();
    test_compress_attack();
    test_steady();
    test_release();
    test_comp_lim();
    test_mode_change();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
